timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped countdown timer that answers CPU load/store traffic in the timer windows (TC0 at 0x7f00, TC1 at 0x7f10). Two instances are placed behind the system bridge.
- Word-only accesses are guaranteed upstream; unaligned, non-word and COUNT-write traffic raise AdEL/AdES in the M stage and never reach this block.
- The block still behaves defined if such traffic arrives.
- Outputs: a read-data mux and a level interrupt request to CP0.

Parameters:
- none (all widths fixed at 32 bits)

Ports:
- TC_i_clk  in  1  system clock, rising edge
- TC_i_reset_n  in  1  asynchronous, active-low reset
- TC_i_Addr  in  32  byte address; only [3:2] decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved)
- TC_i_WEnable  in  1  write strobe, already gated by bridge select and exception-free M stage
- TC_i_WData  in  32  write data
- TC_o_RData  out  32  combinational read data for TC_i_Addr
- TC_o_IRQ  out  1  interrupt request to CP0 IP line

Behaviour:
- Registers:
  - CTRL[3:0]: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask, 1 = enabled).
  - CTRL[31:4] reads 0, writes ignored.
  - PRESET[31:0]: read/write.
  - COUNT[31:0]: read-only. Writes are ignored, no side effect.
  - Address 3: reads 0, writes ignored.
- Reset (async, TC_i_reset_n=0):
  - CTRL=0, PRESET=0, COUNT=0, state=IDLE, pending=0.
  - TC_o_IRQ=0 immediately, TC_o_RData follows register values (0).
- Register writes take effect at the clock edge where TC_i_WEnable=1. A write has priority over any FSM update of the same field in that cycle.
- FSM (one transition per clock edge):
  - IDLE: EN=1 -> LOAD; else stay.
  - LOAD: COUNT<=PRESET -> CNT. If EN=0 -> IDLE, COUNT unchanged.
  - CNT:
    - EN=0 -> IDLE, COUNT frozen.
    - COUNT>1: COUNT<=COUNT-1.
    - COUNT<=1: COUNT<=0, pending<=1 -> INT.
  - INT:
    - MODE 00: EN<=0 (unless CTRL written this cycle) -> IDLE.
    - MODE 01: -> IDLE. EN stays 1, so the next LOAD reloads PRESET.
- Period:
  - PRESET=N (N>=1): pending rises at the edge ending CNT cycle N.
  - Auto-reload period = N+3 cycles (LOAD + N CNT + INT + IDLE).
  - PRESET=0 behaves as PRESET=1. No underflow or wrap-around: COUNT never goes below 0.
- Pending / IRQ:
  - TC_o_IRQ = pending & IM, combinational from registers.
  - MODE 00: pending held until a CTRL write with WData[0]=1, or any PRESET write. Clearing happens at that write edge.
  - MODE 01: pending clears automatically one cycle after it sets (one-cycle pulse). Writes also clear it.
  - If a clearing write and a pending-set event coincide, set wins (no lost interrupt).
- Mid-operation writes:
  - PRESET write during CNT does not alter COUNT; it is used at the next LOAD.
  - CTRL write with EN=0 during LOAD/CNT/INT: IDLE next edge, COUNT holds its value.
  - MODE change during CNT applies at the next INT.
- Async reset asserted in any state: everything returns to reset values at once. Counting resumes only after software re-enables.
- TC_o_RData:
  - Pure combinational mux.
  - A read in the same cycle as a write returns the pre-write value.

Test Plan:
- Reset release, read addr 0/4/8/0xc -> all 0x00000000, TC_o_IRQ=0. Assert reset mid-count (COUNT=5) -> COUNT=0, IRQ=0 without waiting for an edge.
- Write PRESET=3, then CTRL=0x9 (one-shot, IM=1):
  - COUNT reads 3,2,1,0 on successive CNT cycles.
  - IRQ=1 the cycle after CNT sees 1, and stays 1 for 20 cycles.
  - CTRL reads 0x8 (EN auto-cleared).
  - Write CTRL=0x9 -> IRQ=0 next cycle, and the countdown restarts.
- CTRL=0xB (auto-reload, PRESET=4) -> IRQ one-cycle pulses exactly 7 cycles apart, for at least 3 periods.
- Write PRESET=10 while COUNT=6 in CNT -> COUNT continues 5,4,... Next period loads 10.
- CTRL=0x1 (IM=0), PRESET=2 -> COUNT reaches 0 and IRQ stays 0. Then write CTRL=0x8 -> IRQ=1, because pending is retained.
- Write 0x1234 to COUNT (addr 8) during CNT, and 0xFFFFFFFF to CTRL:
  - COUNT is unaffected by the COUNT write.
  - CTRL reads 0xF.
  - PRESET=0 with EN=1 -> IRQ after a single CNT cycle.

Source files
------------

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter
// Purpose  : Memory-mapped 32-bit countdown timer with a level interrupt.
//            Decodes TC_i_Addr[3:2]: 0 CTRL, 1 PRESET, 2 COUNT (read-only),
//            3 reserved (reads 0, writes ignored).
//            CTRL[0] EN, CTRL[2:1] MODE (01 auto-reload, else one-shot),
//            CTRL[3] IM (interrupt enable).
// Ports    : TC_i_clk       - system clock, rising edge
//            TC_i_reset_n   - asynchronous active-low reset
//            TC_i_Addr      - byte address, only bits [3:2] decoded
//            TC_i_WEnable   - write strobe
//            TC_i_WData     - write data
//            TC_o_RData     - combinational read data for TC_i_Addr
//            TC_o_IRQ       - interrupt request (pending & IM)
// Revision : 1.0 - initial release
// ============================================================================
module timer_counter (
    input  logic        TC_i_clk,
    input  logic        TC_i_reset_n,
    input  logic [31:0] TC_i_Addr,
    input  logic        TC_i_WEnable,
    input  logic [31:0] TC_i_WData,
    output logic [31:0] TC_o_RData,
    output logic        TC_o_IRQ
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [3:0]  ctrl, ctrl_next;
    logic [31:0] preset, preset_next;
    logic [31:0] count, count_next;
    logic        pending, pending_next;

    logic [1:0]  reg_sel;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        en;
    logic        auto_mode;
    logic        pending_set;
    logic        pending_auto_clr;
    logic        en_clear;
    logic        unused_addr_bits;

    assign reg_sel          = TC_i_Addr[3:2];
    assign unused_addr_bits = ^{TC_i_Addr[31:4], TC_i_Addr[1:0]};
    assign ctrl_wr          = TC_i_WEnable && (reg_sel == ADDR_CTRL);
    assign preset_wr        = TC_i_WEnable && (reg_sel == ADDR_PRESET);
    assign en               = ctrl[0];
    // MODE 1x behaves like one-shot, so only the exact 01 pattern reloads.
    assign auto_mode        = (ctrl[2:1] == MODE_AUTO);

    // State register and all architectural registers.
    always_ff @(posedge TC_i_clk or negedge TC_i_reset_n) begin
        if (!TC_i_reset_n) begin
            state   <= ST_IDLE;
            ctrl    <= 4'h0;
            preset  <= 32'h0;
            count   <= 32'h0;
            pending <= 1'b0;
        end else begin
            state   <= state_next;
            ctrl    <= ctrl_next;
            preset  <= preset_next;
            count   <= count_next;
            pending <= pending_next;
        end
    end

    // Next-state and register update logic.
    always_comb begin
        state_next       = state;
        count_next       = count;
        pending_set      = 1'b0;
        pending_auto_clr = 1'b0;
        en_clear         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else begin
                    count_next = preset;
                    state_next = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    // Covers COUNT==0 too, so PRESET=0 acts as PRESET=1
                    // and the counter never wraps.
                    count_next  = 32'h0;
                    pending_set = 1'b1;
                    state_next  = ST_INT;
                end
            end
            ST_INT: begin
                state_next = ST_IDLE;
                if (auto_mode) begin
                    pending_auto_clr = 1'b1;
                end else begin
                    en_clear = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Software writes override the one-shot EN auto-clear.
        if (ctrl_wr) begin
            ctrl_next = TC_i_WData[3:0];
        end else if (en_clear) begin
            ctrl_next = {ctrl[3:1], 1'b0};
        end else begin
            ctrl_next = ctrl;
        end

        preset_next = preset_wr ? TC_i_WData : preset;

        // A set in the same cycle as a clear wins so no interrupt is lost.
        if (pending_set) begin
            pending_next = 1'b1;
        end else if ((ctrl_wr && TC_i_WData[0]) || preset_wr || pending_auto_clr) begin
            pending_next = 1'b0;
        end else begin
            pending_next = pending;
        end
    end

    // Read mux reflects register contents before any same-cycle write.
    always_comb begin
        TC_o_RData = 32'h0;
        case (reg_sel)
            ADDR_CTRL:   TC_o_RData = {28'h0, ctrl};
            ADDR_PRESET: TC_o_RData = preset;
            ADDR_COUNT:  TC_o_RData = count;
            default:     TC_o_RData = 32'h0;
        endcase
    end

    assign TC_o_IRQ = pending & ctrl[3];

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_timer_counter
// Purpose  : Self-checking bench for timer_counter. A table of per-cycle
//            {write, address, data, expected read data, expected IRQ}
//            records covers register access and one-shot behaviour; short
//            hand-written sequences cover auto-reload spacing, mid-count
//            PRESET writes and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_counter;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    timer_counter dut (
        .TC_i_clk     (clk),
        .TC_i_reset_n (rst_n),
        .TC_i_Addr    (addr),
        .TC_i_WEnable (we),
        .TC_i_WData   (wdata),
        .TC_o_RData   (rdata),
        .TC_o_IRQ     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] er, input logic ei);
        vec_t v;
        v.we      = w;
        v.addr    = a;
        v.wdata   = d;
        v.exp_rd  = er;
        v.exp_irq = ei;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns
    // later, well before the rising edge that commits any write.
    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = w;
        addr  = a;
        wdata = d;
        #1;
    endtask

    initial begin
        int pulses[$];
        logic [31:0] seq_cnt [14];
        logic        seq_irq [14];

        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        rst_n = 1'b1;

        // ---------------- Vector table ----------------
        // Reset state of every address.
        add(0, 32'h0, 0, 32'h0, 0);
        add(0, 32'h4, 0, 32'h0, 0);
        add(0, 32'h8, 0, 32'h0, 0);
        add(0, 32'hc, 0, 32'h0, 0);
        // One-shot, PRESET=3, IM=1.
        add(1, 32'h4, 3,     32'h0, 0);
        add(1, 32'h0, 32'h9, 32'h0, 0);
        add(0, 32'h8, 0, 32'h0, 0);          // IDLE
        add(0, 32'h8, 0, 32'h0, 0);          // LOAD
        add(0, 32'h8, 0, 32'h3, 0);          // CNT
        add(0, 32'h8, 0, 32'h2, 0);
        add(0, 32'h8, 0, 32'h1, 0);
        add(0, 32'h8, 0, 32'h0, 1);          // INT
        for (int i = 0; i < 20; i++) add(0, 32'h0, 0, 32'h8, 1);   // EN cleared, IRQ held
        add(1, 32'h0, 32'h9, 32'h8, 1);      // restart, clears pending
        add(0, 32'h8, 0, 32'h0, 0);
        add(0, 32'h8, 0, 32'h0, 0);
        add(0, 32'h8, 0, 32'h3, 0);
        add(0, 32'h8, 0, 32'h2, 0);
        add(0, 32'h8, 0, 32'h1, 0);
        add(0, 32'h8, 0, 32'h0, 1);
        // Masked interrupt, pending retained.
        add(1, 32'h4, 2,     32'h3, 1);      // PRESET write clears pending
        add(1, 32'h0, 32'h1, 32'h8, 0);
        add(0, 32'h8, 0, 32'h0, 0);
        add(0, 32'h8, 0, 32'h0, 0);
        add(0, 32'h8, 0, 32'h2, 0);
        add(0, 32'h8, 0, 32'h1, 0);
        add(0, 32'h8, 0, 32'h0, 0);          // INT, masked
        add(0, 32'h0, 0, 32'h0, 0);
        add(1, 32'h0, 32'h8, 32'h0, 0);      // unmask, no clear
        add(0, 32'h0, 0, 32'h8, 1);
        // COUNT write ignored, CTRL upper bits ignored, reserved address.
        add(1, 32'h4, 5,            32'h2, 1);
        add(1, 32'h0, 32'hFFFFFFFF, 32'h8, 0);
        add(0, 32'h0, 0, 32'hF, 0);
        add(0, 32'h8, 0, 32'h0, 0);          // LOAD
        add(1, 32'h8, 32'h1234, 32'h5, 0);
        add(0, 32'h8, 0, 32'h4, 0);
        add(0, 32'hc, 0, 32'h0, 0);
        add(1, 32'hc, 32'hFFFF, 32'h0, 0);
        add(0, 32'h8, 0, 32'h1, 0);
        add(0, 32'h8, 0, 32'h0, 1);          // INT, MODE 11 acts one-shot
        add(0, 32'h0, 0, 32'hE, 1);
        // PRESET=0 acts as PRESET=1.
        add(1, 32'h4, 0,     32'h5, 1);
        add(1, 32'h0, 32'h9, 32'hE, 0);
        add(0, 32'h8, 0, 32'h0, 0);
        add(0, 32'h8, 0, 32'h0, 0);
        add(0, 32'h8, 0, 32'h0, 0);          // single CNT cycle
        add(0, 32'h8, 0, 32'h0, 1);
        add(0, 32'h0, 0, 32'h8, 1);
        // Set wins over clear; CTRL write wins over EN auto-clear; EN=0 freeze.
        add(1, 32'h4, 2,     32'h0, 1);
        add(1, 32'h0, 32'h9, 32'h8, 0);
        add(0, 32'h8, 0, 32'h0, 0);
        add(0, 32'h8, 0, 32'h0, 0);
        add(0, 32'h8, 0, 32'h2, 0);
        add(1, 32'h4, 2,     32'h2, 0);      // clearing write as pending sets
        add(1, 32'h0, 32'hD, 32'h9, 1);      // CTRL write during INT
        add(0, 32'h0, 0, 32'hD, 0);
        add(0, 32'h8, 0, 32'h0, 0);          // LOAD
        add(1, 32'h0, 32'h8, 32'hD, 0);      // disable during CNT
        add(0, 32'h8, 0, 32'h1, 0);
        add(0, 32'h8, 0, 32'h1, 0);
        add(0, 32'h8, 0, 32'h1, 0);

        // ---------------- Asynchronous reset at start ----------------
        #2 rst_n = 1'b0;
        #1;
        chk("rst_irq", 0, {31'h0, irq}, 32'h0);
        chk("rst_ctrl", 0, rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            chk("vec_rdata", i, rdata, vecs[i].exp_rd);
            chk("vec_irq", i, {31'h0, irq}, {31'h0, vecs[i].exp_irq});
        end

        // ---------------- Auto-reload, PRESET=4: period 7 ----------------
        drive(1, 32'h4, 32'd4);
        drive(1, 32'h0, 32'hB);
        for (int k = 0; k < 40; k++) begin
            drive(0, 32'h8, 32'h0);
            if (irq === 1'b1) pulses.push_back(k);
        end
        chk("auto_pulses", 0, pulses.size(), 5);
        if (pulses.size() > 0) chk("auto_first", 0, pulses[0], 6);
        for (int i = 1; i < pulses.size(); i++) chk("auto_gap", i, pulses[i] - pulses[i-1], 7);

        // Reset mid-count (COUNT=2 here) takes effect without a clock edge.
        rst_n = 1'b0;
        #1;
        chk("rst_async_cnt", 0, rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- PRESET write mid-count ----------------
        drive(1, 32'h4, 32'd8);
        drive(1, 32'h0, 32'hB);
        drive(0, 32'h8, 0); chk("mid_cnt", 0, rdata, 32'd0);
        drive(0, 32'h8, 0); chk("mid_cnt", 1, rdata, 32'd0);
        drive(0, 32'h8, 0); chk("mid_cnt", 2, rdata, 32'd8);
        drive(0, 32'h8, 0); chk("mid_cnt", 3, rdata, 32'd7);
        drive(1, 32'h4, 32'd10); chk("mid_preset", 0, rdata, 32'd8);   // COUNT=6 now
        seq_cnt = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0,
                    32'd10, 32'd9, 32'd8, 32'd7, 32'd6, 32'd5};
        seq_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            drive(0, 32'h8, 0);
            chk("reload_cnt", i, rdata, seq_cnt[i]);
            chk("reload_irq", i, {31'h0, irq}, {31'h0, seq_irq[i]});
        end

        // ---------------- Reset at COUNT=5 ----------------
        rst_n = 1'b0;
        #1;
        chk("rst5_cnt", 0, rdata, 32'h0);
        chk("rst5_irq", 0, {31'h0, irq}, 32'h0);
        addr = 32'h0;
        #1;
        chk("rst5_ctrl", 0, rdata, 32'h0);
        addr = 32'h4;
        #1;
        chk("rst5_preset", 0, rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 32'h8, 0);
            chk("post_rst_cnt", i, rdata, 32'h0);
            chk("post_rst_irq", i, {31'h0, irq}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
